hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage core. It works alongside the combinational forwarding logic and covers the hazards forwarding cannot resolve: load-use, multi-cycle multiply occupancy of EX, data-cache miss in MEM, and taken-branch flush. It drives per-stage stall (hold pipeline register) and flush (insert bubble) controls into the F/D/E/M/W pipeline registers.

Parameters:
REG_W, 5, register-index width
MUL_LAT, 4, EX cycles a multiply occupies (min 1)
PERF_W, 16, perf counter width (only with HAZARD_PERF_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rs1_D  input  REG_W  source 1 of instruction in Decode
rs2_D  input  REG_W  source 2 of instruction in Decode
rd_E  input  REG_W  destination of instruction in Execute
memRead_E  input  1  instruction in Execute is a load
regWrite_E  input  1  instruction in Execute writes a register
mulStart_E  input  1  multiply entered Execute this cycle
branchTaken_E  input  1  branch resolved taken in Execute
dcacheMiss_M  input  1  MEM access missed (pulse, first miss cycle)
dcacheReady_M  input  1  miss data returned (single-cycle pulse)
stallF, stallD, stallE, stallM  output  1 each  hold stage register
flushD, flushE, flushM, flushW  output  1 each  load bubble into stage register
state_o  output  2  00 RUN, 01 MUL_BUSY, 10 MEM_WAIT
perf_stall_cnt  output  PERF_W  stall-cycle count (0 without feature)

Behaviour:
- All outputs combinational from state register, counter and inputs. While rst_n is low: state=RUN, counter=0, every output 0. Reset mid-MUL_BUSY or MEM_WAIT aborts to RUN immediately.
- RUN, priority from highest:
  1. dcacheMiss_M: stallF/D/E/M=1, flushW=1. Next state MEM_WAIT. Branch, mul and load-use ignored this cycle; they re-evaluate after release because E is held.
  2. branchTaken_E: flushD=1, flushE=1, no stalls. Overrides load-use.
  3. mulStart_E and MUL_LAT>1: stallF/D/E=1, flushM=1. Counter=MUL_LAT-1. Next state MUL_BUSY. MUL_LAT=1 means no stall.
  4. Load-use: memRead_E & regWrite_E & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D) gives stallF=1, stallD=1, flushE=1 for exactly that cycle. No state change.
- MUL_BUSY: stallF/D/E=1 and flushM=1 every cycle. Counter decrements each cycle. When counter==1, next state RUN. Total stall = MUL_LAT-1 cycles after the entry cycle. mulStart_E is ignored while busy. Load-use is not evaluated.
- MEM_WAIT: stallF/D/E/M=1 and flushW=1 until dcacheReady_M. In the ready cycle all stalls and flushes are 0 and next state is RUN. Ready and a new miss in the same cycle: ready is consumed, miss is ignored (M advances).
- Counter width: clog2(MUL_LAT), minimum 1. It never wraps below 0.
- No output is asserted in a cycle with no hazard condition.

Optional Feature:
HAZARD_PERF_EN:
- With the macro: perf_stall_cnt increments by 1 each cycle stallF=1. Saturates at all-ones. Cleared only by rst_n.
- Without the macro: no counter register; perf_stall_cnt is tied to 0.

Test Plan:
- Load-use: rd_E=5, memRead_E=1, regWrite_E=1, rs2_D=5. Expect stallF=stallD=flushE=1 for 1 cycle; repeat with rd_E=0 and expect all 0.
- Branch vs load-use: same load-use stimulus plus branchTaken_E=1. Expect flushD=flushE=1, stallF=stallD=0.
- Multiply: MUL_LAT=4, mulStart_E pulse. Expect stallF/D/E=1 and flushM=1 for 4 cycles total, with state_o 01 for 3 cycles then 00.
- Cache miss: dcacheMiss_M pulse, dcacheReady_M 6 cycles later. Expect stallF/D/E/M=1 and flushW=1 for 6 cycles, 0 in the ready cycle, state_o back to 00.
- Miss over mul: dcacheMiss_M and mulStart_E same cycle. Expect MEM_WAIT first; after ready with mulStart_E still high, MUL_BUSY entered.
- Reset mid-MEM_WAIT: drop rst_n. Expect all outputs 0 and state_o=00 asynchronously; with HAZARD_PERF_EN, perf_stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush for load-use, multi-cycle multiply,
// D-cache miss and taken branch. Optional stall-cycle perf counter under `HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  rs1_D,
  input  logic [REG_W-1:0]  rs2_D,
  input  logic [REG_W-1:0]  rd_E,
  input  logic              memRead_E,
  input  logic              regWrite_E,
  input  logic              mulStart_E,
  input  logic              branchTaken_E,
  input  logic              dcacheMiss_M,
  input  logic              dcacheReady_M,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  localparam int CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit MUL_STALL = (MUL_LAT > 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_BUSY = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic load_use;

  assign load_use = memRead_E && regWrite_E && (rd_E != '0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;

    case (state_q)
      RUN: begin
        if (dcacheMiss_M) begin
          // Holding E means branch/mul/load-use are re-evaluated once the miss clears.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
          state_d = MEM_WAIT;
        end else if (branchTaken_E) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (mulStart_E && MUL_STALL) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          cnt_d   = CNT_W'(MUL_LAT - 1);
          state_d = MUL_BUSY;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      MUL_BUSY: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end

      MEM_WAIT: begin
        // A miss arriving with ready is dropped: M advances on the ready cycle.
        if (dcacheReady_M) begin
          state_d = RUN;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign stallF  = rst_n & stall_f;
  assign stallD  = rst_n & stall_d;
  assign stallE  = rst_n & stall_e;
  assign stallM  = rst_n & stall_m;
  assign flushD  = rst_n & flush_d;
  assign flushE  = rst_n & flush_e;
  assign flushM  = rst_n & flush_m;
  assign flushW  = rst_n & flush_w;
  assign state_o = rst_n ? state_q : RUN;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (stallF && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_LAT=4); perf expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam int REG_W  = 5;
  localparam int PERF_W = 16;

  // Packed output order: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_0100;
  localparam logic [7:0] O_BR   = 8'b0000_1100;
  localparam logic [7:0] O_MUL  = 8'b1110_0010;
  localparam logic [7:0] O_MISS = 8'b1111_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_W-1:0] rs1_D, rs2_D, rd_E;
  logic memRead_E, regWrite_E, mulStart_E, branchTaken_E, dcacheMiss_M, dcacheReady_M;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic [1:0] state_o;
  logic [PERF_W-1:0] perf_stall_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(4), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_E(rd_E),
    .memRead_E(memRead_E), .regWrite_E(regWrite_E), .mulStart_E(mulStart_E),
    .branchTaken_E(branchTaken_E), .dcacheMiss_M(dcacheMiss_M), .dcacheReady_M(dcacheReady_M),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .state_o(state_o), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare packed controls and state, sampled mid-cycle.
  task automatic expect_out(input string tag, input logic [7:0] o, input logic [1:0] st);
    #2;
    check({tag, ".ctl"}, 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}), 32'(o));
    check({tag, ".st"}, 32'(state_o), 32'(st));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_D = '0; rs2_D = '0; rd_E = '0;
    memRead_E = 0; regWrite_E = 0; mulStart_E = 0;
    branchTaken_E = 0; dcacheMiss_M = 0; dcacheReady_M = 0;
  endtask

  logic [31:0] exp_perf;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    dcacheMiss_M = 1;
    expect_out("reset_miss", O_NONE, 2'b00);
    check("reset_perf", 32'(perf_stall_cnt), 32'd0);
    dcacheMiss_M = 0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("idle", O_NONE, 2'b00);

    // Load-use on rs2
    rd_E = 5; memRead_E = 1; regWrite_E = 1; rs1_D = 3; rs2_D = 5;
    expect_out("loaduse", O_LU, 2'b00);
    tick();
    idle_inputs();
    expect_out("loaduse_after", O_NONE, 2'b00);
    tick();

    // Destination x0 never hazards
    rd_E = 0; memRead_E = 1; regWrite_E = 1; rs1_D = 0; rs2_D = 0;
    expect_out("loaduse_x0", O_NONE, 2'b00);
    tick();

    // Branch overrides load-use
    rd_E = 5; memRead_E = 1; regWrite_E = 1; rs1_D = 5; rs2_D = 5; branchTaken_E = 1;
    expect_out("branch_lu", O_BR, 2'b00);
    tick();
    idle_inputs();

    // Multiply: entry + 3 busy cycles; mulStart_E held high is ignored while busy
    mulStart_E = 1;
    expect_out("mul_entry", O_MUL, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("mul_busy%0d", i), O_MUL, 2'b01);
    end
    tick();
    mulStart_E = 0;
    expect_out("mul_done", O_NONE, 2'b00);
    tick();

    // Cache miss, ready six cycles after the miss pulse
    dcacheMiss_M = 1;
    expect_out("miss_entry", O_MISS, 2'b00);
    tick();
    dcacheMiss_M = 0;
    for (int i = 1; i < 6; i++) begin
      expect_out($sformatf("miss_wait%0d", i), O_MISS, 2'b10);
      tick();
    end
    dcacheReady_M = 1;
    expect_out("miss_ready", O_NONE, 2'b10);
    tick();
    dcacheReady_M = 0;
    expect_out("miss_done", O_NONE, 2'b00);
    tick();

    // Miss beats mul; ready+new miss keeps ready; held mul enters afterwards
    dcacheMiss_M = 1; mulStart_E = 1;
    expect_out("mm_entry", O_MISS, 2'b00);
    tick();
    dcacheMiss_M = 0;
    expect_out("mm_wait1", O_MISS, 2'b10);
    tick();
    expect_out("mm_wait2", O_MISS, 2'b10);
    tick();
    dcacheReady_M = 1; dcacheMiss_M = 1;
    expect_out("mm_ready", O_NONE, 2'b10);
    tick();
    dcacheReady_M = 0; dcacheMiss_M = 0;
    expect_out("mm_mul_entry", O_MUL, 2'b00);
    tick();
    mulStart_E = 0;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("mm_busy%0d", i), O_MUL, 2'b01);
      tick();
    end
    expect_out("mm_done", O_NONE, 2'b00);

    // Stall cycles so far: 1 + 4 + 6 + 3 + 4
`ifdef HAZARD_PERF_EN
    exp_perf = 32'd18;
`else
    exp_perf = 32'd0;
`endif
    check("perf_total", 32'(perf_stall_cnt), exp_perf);
    tick();

    // Reset in the middle of MEM_WAIT
    dcacheMiss_M = 1;
    tick();
    dcacheMiss_M = 0;
    expect_out("rst_pre", O_MISS, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}), 32'd0);
    check("rst_async_st", 32'(state_o), 32'd0);
    check("rst_async_perf", 32'(perf_stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("rst_after", O_NONE, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
